uart_rx: RTL



---
 rtl/uart_rx.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
`timescale 1ns/1ps
// uart_rx: oversampled 8N1 receiver. It feeds a one-entry holding register
// that is read through a valid/ready handshake. Framing errors and overruns
// are reported as single-cycle pulses.
module uart_rx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rx_pin,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic [7:0] rx_data,
  output logic       frame_err,
  output logic       overrun
);

  localparam logic [15:0] C_FULL = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] C_HALF = 16'(HALF_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t      r_state;
  state_t      w_state_nx;
  logic        r_sync1;
  logic        r_sync2;
  logic [15:0] r_bit_cnt;
  logic [2:0]  r_idx;
  logic [7:0]  r_shift;
  logic        r_dlv;
  logic        r_valid;
  logic [7:0]  r_data;
  logic        r_frame_err;
  logic        r_overrun;

  logic        w_rx_s;
  logic        w_sample;
  logic        w_shift;
  logic        w_stop_ok;
  logic        w_stop_bad;
  logic        w_accept;
  logic        w_load;
  logic        w_drop;

  assign w_rx_s    = r_sync2;
  assign w_accept  = r_valid & rx_ready;
  // A pending byte loads when the holding register is empty or is being read this cycle.
  assign w_load    = r_dlv & (~r_valid | rx_ready);
  assign w_drop    = r_dlv & r_valid & ~rx_ready;

  assign rx_valid  = r_valid;
  assign rx_data   = r_data;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;

  // Two-flop synchronizer for the asynchronous serial line (idle high).
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx_pin;
      r_sync2 <= r_sync1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_state_nx;
  end

  // Next-state logic and the sample strobes for each frame phase.
  always_comb begin
    w_state_nx = r_state;
    w_sample   = 1'b0;
    w_shift    = 1'b0;
    w_stop_ok  = 1'b0;
    w_stop_bad = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_rx_s) w_state_nx = S_START;
      end
      S_START: begin
        // Mid-start-bit check rejects short glitches silently.
        if (r_bit_cnt == C_HALF) begin
          w_sample   = 1'b1;
          w_state_nx = w_rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (r_bit_cnt == C_FULL) begin
          w_sample = 1'b1;
          w_shift  = 1'b1;
          if (r_idx == 3'd7) w_state_nx = S_STOP;
        end
      end
      S_STOP: begin
        // Leave at mid-stop-bit so a back-to-back start edge is not missed.
        if (r_bit_cnt == C_FULL) begin
          w_sample = 1'b1;
          if (w_rx_s) begin
            w_stop_ok  = 1'b1;
            w_state_nx = S_IDLE;
          end else begin
            w_stop_bad = 1'b1;
            w_state_nx = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        // A held-low line stays here so it yields one frame error only.
        if (w_rx_s) w_state_nx = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Bit timer: restarts on every state change and every sample.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_bit_cnt <= 16'd0;
    end else if ((w_state_nx != r_state) || w_sample || (r_state == S_IDLE)) begin
      r_bit_cnt <= 16'd0;
    end else begin
      r_bit_cnt <= r_bit_cnt + 16'd1;
    end
  end

  // Deserializer: LSB arrives first, so shift right from the MSB end.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_idx   <= 3'd0;
      r_shift <= 8'h00;
    end else if ((r_state == S_START) && (w_state_nx == S_DATA)) begin
      r_idx <= 3'd0;
    end else if (w_shift) begin
      r_shift <= {w_rx_s, r_shift[7:1]};
      r_idx   <= r_idx + 3'd1;
    end
  end

  // Holding register, handshake and status pulses.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_dlv       <= 1'b0;
      r_valid     <= 1'b0;
      r_data      <= 8'h00;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_dlv       <= w_stop_ok;
      r_frame_err <= w_stop_bad;
      r_overrun   <= w_drop;
      if (w_load) begin
        r_data  <= r_shift;
        r_valid <= 1'b1;
      end else if (w_accept) begin
        r_valid <= 1'b0;
      end
    end
  end

endmodule
